// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmit serializer that pops bytes from a TX FIFO and sends them LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int ClksPerBit = 868,
  parameter int DataWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fifo_empty_i,
  input  logic [DataWidth-1:0] fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 tx_done_o
);

  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int BitW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(ClksPerBit - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_e;

  state_e               r_state, w_next_state;
  logic [CntW-1:0]      r_baud_cnt, w_baud_cnt;
  logic [BitW-1:0]      r_bit_cnt, w_bit_cnt;
  logic [DataWidth-1:0] r_shift, w_shift, w_shift_r1;
  logic                 r_tx, w_tx;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 w_baud_last, w_bit_last;

`ifdef UART_TX_PARITY_EN
  logic r_parity, w_parity;

  function automatic logic even_parity(input logic [DataWidth-1:0] d);
    return ^d;
  endfunction
`endif

  assign w_baud_last = (r_baud_cnt == BaudLast);
  assign w_bit_last  = (r_bit_cnt == BitLast);
  assign w_shift_r1  = r_shift >> 1;

  // The pop request is decoded from state so it can coincide with the tx_done cycle.
  assign fifo_rd_en_o = rst_ni && (r_state == S_IDLE) && !fifo_empty_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty_i) w_next_state = S_FETCH;
        else               w_next_state = S_IDLE;
      end
      S_FETCH: w_next_state = S_START;
      S_START: begin
        if (w_baud_last) w_next_state = S_DATA;
        else             w_next_state = S_START;
      end
      S_DATA: begin
        if (w_baud_last && w_bit_last) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end else begin
          w_next_state = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) w_next_state = S_STOP;
        else             w_next_state = S_PARITY;
      end
`endif
      S_STOP: begin
        if (w_baud_last) w_next_state = S_IDLE;
        else             w_next_state = S_STOP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output and datapath next values; tx is set one cycle ahead so the line is registered
  always_comb begin
    w_tx       = r_tx;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_baud_cnt = r_baud_cnt + {{(CntW-1){1'b0}}, 1'b1};
    w_done     = 1'b0;
    w_busy     = (w_next_state != S_IDLE);
`ifdef UART_TX_PARITY_EN
    w_parity   = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx       = 1'b1;
        w_bit_cnt  = {BitW{1'b0}};
        w_baud_cnt = {CntW{1'b0}};
      end
      S_FETCH: begin
        w_shift    = fifo_rd_data_i;
        w_tx       = 1'b0;
        w_bit_cnt  = {BitW{1'b0}};
        w_baud_cnt = {CntW{1'b0}};
`ifdef UART_TX_PARITY_EN
        w_parity   = even_parity(fifo_rd_data_i);
`endif
      end
      S_START: begin
        if (w_baud_last) begin
          w_tx       = r_shift[0];
          w_baud_cnt = {CntW{1'b0}};
        end else begin
          w_tx = 1'b0;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_cnt = {CntW{1'b0}};
          if (w_bit_last) begin
            w_bit_cnt = {BitW{1'b0}};
`ifdef UART_TX_PARITY_EN
            w_tx      = r_parity;
`else
            w_tx      = 1'b1;
`endif
          end else begin
            w_shift   = w_shift_r1;
            w_tx      = w_shift_r1[0];
            w_bit_cnt = r_bit_cnt + {{(BitW-1){1'b0}}, 1'b1};
          end
        end else begin
          w_tx = r_tx;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_tx       = 1'b1;
          w_baud_cnt = {CntW{1'b0}};
        end else begin
          w_tx = r_tx;
        end
      end
`endif
      S_STOP: begin
        w_tx = 1'b1;
        if (w_baud_last) begin
          w_done     = 1'b1;
          w_baud_cnt = {CntW{1'b0}};
        end else begin
          w_done = 1'b0;
        end
      end
      default: begin
        w_tx       = 1'b1;
        w_baud_cnt = {CntW{1'b0}};
      end
    endcase
  end

  // Datapath and registered outputs; tx returns high asynchronously on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= {DataWidth{1'b0}};
      r_bit_cnt  <= {BitW{1'b0}};
      r_baud_cnt <= {CntW{1'b0}};
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_tx       <= w_tx;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_baud_cnt <= w_baud_cnt;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity;
`endif
    end
  end

  assign tx_o      = r_tx;
  assign busy_o    = r_busy;
  assign tx_done_o = r_done;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer: pulls bytes from the TX FIFO's read port and shifts each one out on the serial line as an 8N1 frame, LSB first. An optional even-parity bit can be compiled in. It is the consumer (read side) of the UART TX FIFO and drives the SoC's `uart_tx` pin. Baud timing comes from an internal clock-cycle divider.

## Interface
- `ClksPerBit`, default 868, clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `DataWidth`, default 8, frame data bits; the FIFO width must match.
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `fifo_empty_i`  in  1  TX FIFO empty flag.
- `fifo_rd_data_i`  in  DataWidth  FIFO read data; valid the cycle after `fifo_rd_en_o` is asserted.
- `fifo_rd_en_o`  out  1  FIFO pop request; single-cycle pulse.
- `tx_o`  out  1  serial line, registered, idles high.
- `busy_o`  out  1  high in every state except IDLE.
- `tx_done_o`  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- FSM states: IDLE, FETCH, START, DATA, PARITY (only when the feature is compiled in), STOP.
- **IDLE**
  - `fifo_rd_en_o = !fifo_empty_i`, combinational from state; forced to 0 while `rst_ni` is low.
  - If not empty, go to FETCH.
- **FETCH**
  - Latch `fifo_rd_data_i` into the shift register.
  - Go to START; `tx_o <= 0`.
- **START**
  - Hold `tx_o = 0` for `ClksPerBit` cycles.
  - Then go to DATA; `tx_o <= shift[0]`.
- **DATA**
  - Each bit is held `ClksPerBit` cycles; then shift right and increment the 3-bit counter.
  - After bit `DataWidth-1`, go to PARITY (if enabled) or STOP.
- **STOP**
  - Hold `tx_o = 1` for `ClksPerBit` cycles.
  - Then go to IDLE with `tx_done_o = 1` for that one cycle.
- Baud counter: width `$clog2(ClksPerBit)`. Cleared on every state/bit transition; counts 0 to `ClksPerBit-1`.
- Exactly one FIFO pop per frame. An empty FIFO never causes a pop. `fifo_empty_i` is ignored outside IDLE.
- Reset values: state IDLE, `tx_o = 1`, `busy_o = 0`, `tx_done_o = 0`, `fifo_rd_en_o = 0`, all counters and the shift register 0.
- Reset mid-frame: `tx_o` returns high immediately (asynchronous). The partial frame is abandoned; no `tx_done_o`.

## Timing
- Cycle 0: IDLE with FIFO non-empty; `fifo_rd_en_o = 1`.
- Cycle 1: FETCH.
- Cycle 2: `tx_o` falls (start bit).
- Frame length on `tx_o`: `(2+DataWidth)·ClksPerBit` cycles, or `+ClksPerBit` with parity.
- Back-to-back frames:
  - `fifo_rd_en_o` can assert in the same cycle as `tx_done_o`.
  - The line stays high for 2 extra cycles (IDLE + FETCH) between stop and start.
  - Frame period is `10·ClksPerBit + 2` (8N1).
- `busy_o` is high from the FETCH cycle through the last STOP cycle.
- `tx_done_o` is never high for two consecutive cycles.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is present.
  - After D7, `tx_o` carries even parity (XOR of the data bits) for `ClksPerBit` cycles; frame is 11 bits.
- Undefined:
  - No PARITY state or parity logic; DATA goes directly to STOP; frame is 10 bits.

## Test plan
- **Reset:** hold `rst_ni = 0` with FIFO non-empty -> `tx_o = 1`, `busy_o = 0`, `fifo_rd_en_o = 0`, `tx_done_o = 0`.
- **Single byte:** `ClksPerBit = 4`, FIFO holds 0xA5.
  - `fifo_rd_en_o` pulses exactly once.
  - `tx_o` from cycle 2 is 0,1,0,1,0,0,1,0,1,1, 4 cycles each.
  - `tx_done_o` pulses at cycle 42.
- **Back-to-back:** `ClksPerBit = 4`, FIFO holds 0x00 then 0xFF.
  - Start bits fall 42 cycles apart.
  - Exactly two pops.
  - Two `tx_done_o` pulses.
- **Empty FIFO:** FIFO empty for 1000 cycles -> no `fifo_rd_en_o`, `tx_o` constantly 1, `busy_o = 0`.
- **Mid-frame reset:** `rst_ni` low during DATA bit 3 -> `tx_o = 1` in the same cycle, no `tx_done_o`. After release, the next FIFO byte is sent as a complete, correct frame.
- **Parity (`UART_TX_PARITY_EN`):** byte 0x07 -> parity bit 1, then stop 1. Byte 0x03 -> parity bit 0; frame is 11 bits long.
